turbo_rsc_pair_encoder: RTL

//  Downstream consumer of the interleaver's bit-serial outputs (outi = c_i, outpii = c_pi(i)).
//  Two LTE 8-state RSC constituent encoders, G = [1, g1/g0], g0 = 1+D^2+D^3, g1 = 1+D+D^3.

---
 rtl/turbo_rsc_pair_encoder_pkg.sv | 23 ++
 rtl/turbo_rsc_pair_encoder_if.sv | 31 +++
 rtl/turbo_rsc_pair_encoder_rsc_encoder.sv | 43 ++++
 rtl/turbo_rsc_pair_encoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/turbo_rsc_pair_encoder_pkg.sv
// rtl/turbo_rsc_pair_encoder_pkg.sv - shared constants and FSM encoding for the turbo RSC pair encoder
package turbo_rsc_pair_encoder_pkg;

    localparam int K_SMALL = 1056;
    localparam int K_LARGE = 6144;
    localparam int CNT_W   = 13;

    // Each trellis needs three termination steps
    localparam logic [1:0] TAIL_LAST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TAIL1 = 2'd2,
        ST_TAIL2 = 2'd3
    } state_t;

    // Index of the final information bit for the selected block size
    function automatic logic [CNT_W-1:0] k_last(input logic k_size_6144);
        return k_size_6144 ? CNT_W'(K_LARGE - 1) : CNT_W'(K_SMALL - 1);
    endfunction

endpackage

// File: rtl/turbo_rsc_pair_encoder_if.sv
// rtl/turbo_rsc_pair_encoder_if.sv - control, bit-serial input and encoded output bundle
interface turbo_rsc_pair_encoder_if;

    logic k_size_6144;
    logic start;
    logic bit_valid;
    logic ci;
    logic cpii;

    logic out_valid;
    logic d0;
    logic d1;
    logic d2;
    logic tail;
    logic busy;
    logic block_done;
    logic overrun;

    // Encoder side
    modport slave (
        input  k_size_6144, start, bit_valid, ci, cpii,
        output out_valid, d0, d1, d2, tail, busy, block_done, overrun
    );

    // Producer / consumer side
    modport master (
        output k_size_6144, start, bit_valid, ci, cpii,
        input  out_valid, d0, d1, d2, tail, busy, block_done, overrun
    );

endinterface

// File: rtl/turbo_rsc_pair_encoder_rsc_encoder.sv
// rtl/turbo_rsc_pair_encoder_rsc_encoder.sv - one 8-state RSC constituent encoder (g0=1+D^2+D^3, g1=1+D+D^3)
module rsc_encoder (
    input  logic clock,
    input  logic rst,
    input  logic en,
    input  logic term,
    input  logic clr,
    input  logic c,
    output logic x,
    output logic z
);

    logic r_r1;
    logic r_r2;
    logic r_r3;
    logic w_a;

    // Feedback bit, systematic/tail bit and parity from the current register state.
    // During termination the input is chosen as r2^r3 so the feedback bit becomes 0.
    always_comb begin
        w_a = term ? 1'b0 : (c ^ r_r2 ^ r_r3);
        x   = term ? (r_r2 ^ r_r3) : c;
        z   = w_a ^ r_r1 ^ r_r3;
    end

    // Shift register: clears at block start, advances only when enabled
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_r1 <= 1'b0;
            r_r2 <= 1'b0;
            r_r3 <= 1'b0;
        end else if (clr) begin
            r_r1 <= 1'b0;
            r_r2 <= 1'b0;
            r_r3 <= 1'b0;
        end else if (en) begin
            r_r1 <= w_a;
            r_r2 <= r_r1;
            r_r3 <= r_r2;
        end
    end

endmodule

// File: rtl/turbo_rsc_pair_encoder.sv
// rtl/turbo_rsc_pair_encoder.sv - two RSC encoders with block FSM, trellis termination and registered outputs
module turbo_rsc_pair_encoder
    import turbo_rsc_pair_encoder_pkg::*;
(
    input  logic                     clock,
    input  logic                     rst,
    turbo_rsc_pair_encoder_if.slave  bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   r_k_last;
    logic [CNT_W-1:0]   w_k_last_nxt;
    logic [1:0]         r_tcnt;
    logic [1:0]         w_tcnt_nxt;

    logic r_out_valid, w_out_valid_nxt;
    logic r_d0,        w_d0_nxt;
    logic r_d1,        w_d1_nxt;
    logic r_d2,        w_d2_nxt;
    logic r_tail,      w_tail_nxt;
    logic r_busy,      w_busy_nxt;
    logic r_done,      w_done_nxt;
    logic r_overrun,   w_overrun_nxt;

    logic w_en1, w_term1, w_en2, w_term2, w_clr;
    logic w_x1, w_z1, w_x2, w_z2;

    rsc_encoder u_enc1 (
        .clock (clock),
        .rst   (rst),
        .en    (w_en1),
        .term  (w_term1),
        .clr   (w_clr),
        .c     (bus.ci),
        .x     (w_x1),
        .z     (w_z1)
    );

    rsc_encoder u_enc2 (
        .clock (clock),
        .rst   (rst),
        .en    (w_en2),
        .term  (w_term2),
        .clr   (w_clr),
        .c     (bus.cpii),
        .x     (w_x2),
        .z     (w_z2)
    );

    // Next state, counters, encoder controls and next output values
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_tcnt_nxt      = r_tcnt;
        w_k_last_nxt    = r_k_last;
        w_en1           = 1'b0;
        w_term1         = 1'b0;
        w_en2           = 1'b0;
        w_term2         = 1'b0;
        w_clr           = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_d0_nxt        = 1'b0;
        w_d1_nxt        = 1'b0;
        w_d2_nxt        = 1'b0;
        w_tail_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        // busy is the state decode delayed like every other output, so it
        // drops one cycle after the block_done pulse
        w_busy_nxt      = (r_state != ST_IDLE);
        // Any bit offered while not accepting data is lost; flag it sticky
        w_overrun_nxt   = r_overrun | (bus.bit_valid && (r_state != ST_DATA));

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt   = ST_DATA;
                    w_k_last_nxt  = k_last(bus.k_size_6144);
                    w_cnt_nxt     = '0;
                    w_tcnt_nxt    = '0;
                    w_clr         = 1'b1;
                    // start clears the flag, but a bit in the same cycle is still lost
                    w_overrun_nxt = bus.bit_valid;
                end
            end

            ST_DATA: begin
                if (bus.bit_valid) begin
                    w_en1           = 1'b1;
                    w_en2           = 1'b1;
                    w_out_valid_nxt = 1'b1;
                    w_d0_nxt        = w_x1;
                    w_d1_nxt        = w_z1;
                    w_d2_nxt        = w_z2;
                    if (r_cnt == r_k_last) begin
                        w_state_nxt = ST_TAIL1;
                        w_cnt_nxt   = '0;
                        w_tcnt_nxt  = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_TAIL1: begin
                w_en1           = 1'b1;
                w_term1         = 1'b1;
                w_out_valid_nxt = 1'b1;
                w_tail_nxt      = 1'b1;
                w_d0_nxt        = w_x1;
                w_d1_nxt        = w_z1;
                if (r_tcnt == TAIL_LAST) begin
                    w_state_nxt = ST_TAIL2;
                    w_tcnt_nxt  = '0;
                end else begin
                    w_tcnt_nxt  = r_tcnt + 2'd1;
                end
            end

            ST_TAIL2: begin
                w_en2           = 1'b1;
                w_term2         = 1'b1;
                w_out_valid_nxt = 1'b1;
                w_tail_nxt      = 1'b1;
                w_d0_nxt        = w_x2;
                w_d1_nxt        = w_z2;
                if (r_tcnt == TAIL_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_tcnt_nxt  = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_tcnt_nxt  = r_tcnt + 2'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_tcnt      <= '0;
            r_k_last    <= '0;
            r_out_valid <= 1'b0;
            r_d0        <= 1'b0;
            r_d1        <= 1'b0;
            r_d2        <= 1'b0;
            r_tail      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_k_last    <= w_k_last_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_d0        <= w_d0_nxt;
            r_d1        <= w_d1_nxt;
            r_d2        <= w_d2_nxt;
            r_tail      <= w_tail_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.d0         = r_d0;
    assign bus.d1         = r_d1;
    assign bus.d2         = r_d2;
    assign bus.tail       = r_tail;
    assign bus.busy       = r_busy;
    assign bus.block_done = r_done;
    assign bus.overrun    = r_overrun;

endmodule
